rom_loader: RTL and testbench
=============================

Name: rom_loader

Overview:
- Parametrised successor to the top-level boot-ROM download mapping.
- Accepts byte strobes from the mist_io ioctl download port. Decodes each 16 KB chunk into a (bank, SDRAM slot base) pair from a parameter table, and buffers the writes in a small FIFO.
- Issues SDRAM writes only on sdram clkref slots.
- Signals load completion so the core can release reset and latch the model.
- Supports arbitrary bank and ROM-slot counts with overflow and out-of-range tracking.

Parameters:
- SLOTS, 4: ROM slots per bank (16 KB each).
- NBANKS, 2: number of SDRAM banks/models.
- SLOT_BASE, {9'h1ff,9'h107,9'h100,9'h000}: SLOTS×9-bit packed table, addr[22:14] per slot; slot 0 in the LSBs.
- FIFO_DEPTH, 4: write buffer entries; power of two, ≥2.
- ROM_INDEX, 8'd0: ioctl_index value treated as ROM download.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ioctl_download  in  1  download active.
- ioctl_index  in  8  download target index.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte address in image.
- ioctl_dout  in  8  byte data.
- mem_slot  in  1  sdram clkref; one write may be issued per asserted cycle.
- mem_we  out  1  SDRAM write strobe, one cycle.
- mem_addr  out  23  SDRAM byte address.
- mem_bank  out  2  SDRAM bank; upper bits 0 when NBANKS<4.
- mem_din  out  8  write data.
- busy  out  1  load in progress; holds core in reset.
- done  out  1  one-cycle pulse at load end.
- overflow  out  1  sticky: strobe arrived while FIFO full.
- dropped  out  1  sticky: chunk index ≥ SLOTS×NBANKS.
- csum  out  16  byte checksum (see optional feature).

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; FIFO empty; pointers 0.
- Active load condition: `ioctl_download && ioctl_index == ROM_INDEX`.
- Chunk decode: `idx = ioctl_addr[24:14]`, `slot = idx % SLOTS`, `bank = idx / SLOTS`.
  - If `bank ≥ NBANKS`: byte discarded, `dropped` ← 1, no push.
  - Otherwise `mem_addr = {SLOT_BASE[slot], ioctl_addr[13:0]}`.
- FSM:
  - IDLE → LOAD on rising active condition. Clears `overflow`, `dropped` and `csum`; `busy` ← 1.
  - LOAD: each `ioctl_wr` pushes {bank, addr, data}. LOAD → DRAIN when the active condition falls.
  - DRAIN: pops remaining entries. DRAIN → DONE when FIFO empty and no `mem_we` pending.
  - DONE: `done` = 1 for exactly one cycle, `busy` ← 0, then → IDLE.
- Pop rules:
  - Pop when FIFO non-empty and `mem_slot` = 1.
  - `mem_we`/`mem_addr`/`mem_bank`/`mem_din` are registered and valid the cycle after `mem_slot`.
  - Latency from push to `mem_we`: ≥2 cycles.
- Full FIFO: `ioctl_wr` while full and no pop that cycle → byte lost, `overflow` ← 1. Simultaneous push and pop when full succeeds.
- Empty FIFO: `mem_slot` with empty FIFO → no `mem_we`.
- `ioctl_wr` outside LOAD is ignored.
- Index wrap: `ioctl_addr` beyond the table is flagged via `dropped`, never aliased.
- A new active condition during DRAIN restarts LOAD without flushing the FIFO; flags are not cleared.
- Asynchronous `reset` mid-load aborts immediately: FIFO flushed, no `done`.

Optional Feature:
- Macro: ROM_LOADER_CSUM_EN.
- Defined: `csum` = 16-bit wrap-around sum of every byte actually written to SDRAM (popped), updated on `mem_we`. Cleared on LOAD entry; stable after `done`.
- Undefined: `csum` tied to 0 and no adder is synthesised.

Test Plan:
- Full image, default parameters:
  - Stimulus: 64 KB (4 chunks), bytes = addr[7:0], strobes every 16 cycles, `mem_slot` every 16 cycles.
  - Response: 65536 `mem_we` pulses. Byte 0x4000 goes to addr 0x400000 bank 0; byte 0xC123 goes to 0x7FC123. One `done` pulse; `overflow` = `dropped` = 0.
- Second bank: byte at ioctl_addr 0x14005 → `mem_bank` = 1, `mem_addr` = 0x400005.
- Out-of-range chunk: byte at ioctl_addr 0x20000 (idx 8) → no `mem_we`; `dropped` = 1 after load.
- Overflow: strobes every cycle, `mem_slot` held 0 for 10 cycles → 4 entries kept, `overflow` = 1. After `mem_slot` resumes: exactly 4 writes, then `done`.
- Reset mid-load: `reset` pulsed after 100 bytes → `busy` = `mem_we` = 0 next cycle, no `done`. Reload of 16 bytes completes normally.
- ROM_LOADER_CSUM_EN: bytes 0xFF×258 → `csum` = 0xFF×258 mod 65536 = 0x00FE. Without the macro, `csum` = 0.

Source files
------------

// File: rtl/rom_loader.sv
// rom_loader: maps the mist_io ioctl boot-ROM download onto SDRAM.
// Each 16 KB chunk of the image selects a (bank, slot base) pair from a
// parameter table. Writes are buffered in a small FIFO and issued to the
// SDRAM only on clkref slots. busy/done let the core hold itself in reset
// until the image is in place.
// Optional feature macro: ROM_LOADER_CSUM_EN (16-bit running checksum of
// written bytes on csum; csum is tied to zero when the macro is undefined).
module rom_loader #(
    parameter int                 SLOTS      = 4,
    parameter int                 NBANKS     = 2,
    parameter logic [SLOTS*9-1:0] SLOT_BASE  = {9'h1ff, 9'h107, 9'h100, 9'h000},
    parameter int                 FIFO_DEPTH = 4,
    parameter logic [7:0]         ROM_INDEX  = 8'd0
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        mem_slot,
    output logic        mem_we,
    output logic [22:0] mem_addr,
    output logic [1:0]  mem_bank,
    output logic [7:0]  mem_din,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        dropped,
    output logic [15:0] csum
);

    localparam int          BASE_W   = 9;
    localparam int          AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          EW       = 2 + 23 + 8;
    localparam logic [10:0] SLOTS_W  = SLOTS[10:0];
    localparam logic [10:0] NBANKS_W = NBANKS[10:0];
    localparam logic [AW:0] DEPTH_W  = FIFO_DEPTH[AW:0];

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Table lookup: SDRAM address bits [22:14] for a given ROM slot.
    function automatic logic [8:0] slot_base(input logic [10:0] slot);
        logic [8:0] base;
        base = 9'h000;
        for (int i = 0; i < SLOTS; i++) begin
            if (slot == i[10:0]) begin
                base = SLOT_BASE[i*BASE_W +: BASE_W];
            end else begin
                base = base;
            end
        end
        return base;
    endfunction

    state_t         state_r;
    state_t         state_next_s;
    logic           load_entry_s;
    logic           active_s;
    logic           active_d_r;
    logic           active_rise_s;

    logic [10:0]    chunk_idx_s;
    logic [10:0]    slot_s;
    logic [10:0]    bank_full_s;
    logic           in_range_s;
    logic [EW-1:0]  push_data_s;

    logic [EW-1:0]  fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [AW:0]    count_r;
    logic           empty_s;
    logic           full_s;
    logic           wr_req_s;
    logic           push_s;
    logic           pop_s;
    logic [EW-1:0]  head_s;
    logic [7:0]     head_data_s;

    logic           mem_we_r;
    logic [22:0]    mem_addr_r;
    logic [1:0]     mem_bank_r;
    logic [7:0]     mem_din_r;
    logic           busy_r;
    logic           done_r;
    logic           overflow_r;
    logic           dropped_r;

    assign active_s      = ioctl_download && (ioctl_index == ROM_INDEX);
    assign active_rise_s = active_s && !active_d_r;

    // Chunk decode: the 16 KB chunk number picks the slot and bank; chunks
    // past the table are rejected rather than wrapped onto a valid slot.
    assign chunk_idx_s = ioctl_addr[24:14];
    assign slot_s      = chunk_idx_s % SLOTS_W;
    assign bank_full_s = chunk_idx_s / SLOTS_W;
    assign in_range_s  = (bank_full_s < NBANKS_W);
    assign push_data_s = {bank_full_s[1:0], slot_base(slot_s), ioctl_addr[13:0], ioctl_dout};

    assign empty_s     = (count_r == {(AW+1){1'b0}});
    assign full_s      = (count_r == DEPTH_W);
    assign pop_s       = !empty_s && mem_slot;
    assign wr_req_s    = (state_r == ST_LOAD) && ioctl_wr;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push_s      = wr_req_s && in_range_s && (!full_s || pop_s);
    assign head_s      = fifo_mem_r[rd_ptr_r];
    assign head_data_s = head_s[7:0];

    // Previous active condition, used to detect the start of a ROM download.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            active_d_r <= 1'b0;
        end else begin
            active_d_r <= active_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state; a fresh load from IDLE/DONE also clears flags.
    always_comb begin
        state_next_s = state_r;
        load_entry_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (active_rise_s) begin
                    state_next_s = ST_LOAD;
                    load_entry_s = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (!active_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (active_rise_s) begin
                    // Restart keeps the FIFO contents and the sticky flags.
                    state_next_s = ST_LOAD;
                end else if (empty_s && !mem_we_r) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (active_rise_s) begin
                    state_next_s = ST_LOAD;
                    load_entry_s = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                load_entry_s = 1'b0;
            end
        endcase
    end

    // FIFO storage; validity is tracked by the pointers, so no reset needed.
    always_ff @(posedge clk_sys) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= push_data_s;
        end else begin
            fifo_mem_r[wr_ptr_r] <= fifo_mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers and occupancy; reset flushes any pending writes.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + 1'b1;
            end else if (pop_s && !push_s) begin
                count_r <= count_r - 1'b1;
            end else begin
                count_r <= count_r;
            end
        end
    end

    // SDRAM write port: one registered write per clkref slot with data queued.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            mem_we_r   <= 1'b0;
            mem_addr_r <= 23'h000000;
            mem_bank_r <= 2'b00;
            mem_din_r  <= 8'h00;
        end else begin
            mem_we_r <= pop_s;
            if (pop_s) begin
                mem_bank_r <= head_s[32:31];
                mem_addr_r <= head_s[30:8];
                mem_din_r  <= head_s[7:0];
            end else begin
                mem_bank_r <= mem_bank_r;
                mem_addr_r <= mem_addr_r;
                mem_din_r  <= mem_din_r;
            end
        end
    end

    // Status outputs follow the next state so they align with the FSM.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s == ST_LOAD) || (state_next_s == ST_DRAIN);
            done_r <= (state_next_s == ST_DONE);
        end
    end

    // Sticky error flags, cleared only when a new load starts from idle.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            overflow_r <= 1'b0;
            dropped_r  <= 1'b0;
        end else if (load_entry_s) begin
            overflow_r <= 1'b0;
            dropped_r  <= 1'b0;
        end else begin
            overflow_r <= overflow_r || (wr_req_s && in_range_s && full_s && !pop_s);
            dropped_r  <= dropped_r || (wr_req_s && !in_range_s);
        end
    end

`ifdef ROM_LOADER_CSUM_EN
    logic [15:0] csum_r;

    // Running sum of every byte handed to the SDRAM, restarted per load.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            csum_r <= 16'h0000;
        end else if (load_entry_s) begin
            csum_r <= 16'h0000;
        end else if (pop_s) begin
            csum_r <= csum_r + {8'h00, head_data_s};
        end else begin
            csum_r <= csum_r;
        end
    end

    assign csum = csum_r;
`else
    assign csum = 16'h0000;
`endif

    assign mem_we   = mem_we_r;
    assign mem_addr = mem_addr_r;
    assign mem_bank = mem_bank_r;
    assign mem_din  = mem_din_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign overflow = overflow_r;
    assign dropped  = dropped_r;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader with default parameters.
module tb_rom_loader;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        mem_slot;
    logic        mem_we;
    logic [22:0] mem_addr;
    logic [1:0]  mem_bank;
    logic [7:0]  mem_din;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        dropped;
    logic [15:0] csum;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int slot_mode = 1;   // 0: slot held low, 1: every cycle, 2: every 4th cycle
    int done_cnt = 0;

    logic [22:0] cap_addr [$];
    logic [1:0]  cap_bank [$];
    logic [7:0]  cap_data [$];

    rom_loader dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .mem_slot       (mem_slot),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_bank       (mem_bank),
        .mem_din        (mem_din),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow),
        .dropped        (dropped),
        .csum           (csum)
    );

    always #5 clk_sys = ~clk_sys;

    // Capture every SDRAM write and done pulse mid-cycle.
    always @(negedge clk_sys) begin
        if (mem_we === 1'b1) begin
            cap_addr.push_back(mem_addr);
            cap_bank.push_back(mem_bank);
            cap_data.push_back(mem_din);
        end
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
        cyc++;
        mem_slot = (slot_mode == 1) || ((slot_mode == 2) && (cyc % 4 == 0));
    endtask

    task automatic clear_cap();
        cap_addr.delete();
        cap_bank.delete();
        cap_data.delete();
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input int gap);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
        for (int g = 0; g < gap; g++) tick();
    endtask

    task automatic start_load();
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        tick();
        tick();
    endtask

    task automatic wait_done(input int budget);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        ioctl_download = 1'b0;
        while (!seen && n < budget) begin
            tick();
            n++;
            if (done === 1'b1) seen = 1'b1;
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            check("busy_low_at_done", {31'd0, busy}, 32'd0);
            tick();
            check("done_one_cycle", {31'd0, done}, 32'd0);
        end
    endtask

    task automatic check_write(input string tag, input int k, input logic [22:0] a,
                               input logic [1:0] b, input logic [7:0] d);
        if (cap_addr.size() > k) begin
            check({tag, "_addr"}, {9'd0, cap_addr[k]}, {9'd0, a});
            check({tag, "_bank"}, {30'd0, cap_bank[k]}, {30'd0, b});
            check({tag, "_data"}, {24'd0, cap_data[k]}, {24'd0, d});
        end else begin
            check({tag, "_present"}, cap_addr.size(), k + 1);
        end
    endtask

    initial begin
        int dc;
        reset = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index = 8'd0;
        ioctl_wr = 1'b0;
        ioctl_addr = 25'd0;
        ioctl_dout = 8'd0;
        mem_slot = 1'b0;
        tick();
        tick();
        // Reset state
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", {9'd0, mem_addr}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_dropped", {31'd0, dropped}, 32'd0);
        check("rst_csum", {16'd0, csum}, 32'd0);
        reset = 1'b0;
        tick();
        tick();

        // Download to a non-ROM index is ignored
        ioctl_index = 8'd1;
        ioctl_download = 1'b1;
        tick();
        tick();
        send_byte(25'h0000010, 8'h10, 3);
        check("other_index_busy", {31'd0, busy}, 32'd0);
        check("other_index_writes", cap_addr.size(), 32'd0);
        ioctl_download = 1'b0;
        tick();

        // Sparse image across the four bank-0 chunks, slots every 4 cycles
        clear_cap();
        slot_mode = 2;
        start_load();
        check("load_busy", {31'd0, busy}, 32'd1);
        send_byte(25'h0000000, 8'h00, 0);
        check("push_latency_min", {31'd0, mem_we}, 32'd0);
        for (int g = 0; g < 7; g++) tick();
        send_byte(25'h0004000, 8'h00, 7);
        send_byte(25'h0008042, 8'h42, 7);
        send_byte(25'h000C123, 8'h23, 7);
        send_byte(25'h000FFFF, 8'hFF, 7);
        wait_done(100);
        check("img_writes", cap_addr.size(), 32'd5);
        check_write("img0", 0, 23'h000000, 2'd0, 8'h00);
        check_write("img1", 1, 23'h400000, 2'd0, 8'h00);
        check_write("img2", 2, 23'h41C042, 2'd0, 8'h42);
        check_write("img3", 3, 23'h7FC123, 2'd0, 8'h23);
        check_write("img4", 4, 23'h7FFFFF, 2'd0, 8'hFF);
        check("img_overflow", {31'd0, overflow}, 32'd0);
        check("img_dropped", {31'd0, dropped}, 32'd0);
        check("img_busy_after", {31'd0, busy}, 32'd0);

        // Second bank plus an out-of-range chunk (idx 8 must not alias slot 0)
        clear_cap();
        slot_mode = 1;
        start_load();
        send_byte(25'h0014005, 8'h05, 3);
        send_byte(25'h0020000, 8'h00, 3);
        wait_done(50);
        check("bank1_writes", cap_addr.size(), 32'd1);
        check_write("bank1", 0, 23'h400005, 2'd1, 8'h05);
        check("oor_dropped", {31'd0, dropped}, 32'd1);
        check("oor_overflow", {31'd0, overflow}, 32'd0);

        // Overflow: slots held off while 10 back-to-back strobes arrive
        clear_cap();
        slot_mode = 0;
        start_load();
        check("ovf_dropped_cleared", {31'd0, dropped}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            ioctl_addr = 25'h10 + 25'(i);
            ioctl_dout = 8'h10 + 8'(i);
            ioctl_wr   = 1'b1;
            tick();
        end
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        tick();
        tick();
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        check("ovf_no_write_without_slot", cap_addr.size(), 32'd0);
        check("ovf_busy_stalled", {31'd0, busy}, 32'd1);
        slot_mode = 1;
        wait_done(50);
        check("ovf_writes", cap_addr.size(), 32'd4);
        check_write("ovf_first", 0, 23'h000010, 2'd0, 8'h10);
        check_write("ovf_last", 3, 23'h000013, 2'd0, 8'h13);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Reset mid-load aborts without done; reload then completes
        clear_cap();
        slot_mode = 1;
        start_load();
        for (int i = 0; i < 100; i++) send_byte(25'(i), 8'(i), 1);
        dc = done_cnt;
        reset = 1'b1;
        #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_mem_we", {31'd0, mem_we}, 32'd0);
        ioctl_download = 1'b0;
        tick();
        check("rst_mid_busy_next", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        tick();
        tick();
        check("rst_mid_no_done", done_cnt, dc);
        clear_cap();
        start_load();
        for (int i = 0; i < 16; i++) send_byte(25'h100 + 25'(i), 8'(i), 1);
        wait_done(50);
        check("reload_writes", cap_addr.size(), 32'd16);
        check_write("reload_first", 0, 23'h000100, 2'd0, 8'h00);
        check_write("reload_last", 15, 23'h00010F, 2'd0, 8'h0F);
        check("reload_overflow", {31'd0, overflow}, 32'd0);

        // Checksum: 258 bytes of 0xFF
        clear_cap();
        start_load();
        for (int i = 0; i < 258; i++) send_byte(25'(i), 8'hFF, 1);
        wait_done(50);
        check("csum_writes", cap_addr.size(), 32'd258);
`ifdef ROM_LOADER_CSUM_EN
        check("csum_value", {16'd0, csum}, 32'h000000FE);
        tick();
        tick();
        check("csum_stable", {16'd0, csum}, 32'h000000FE);
`else
        check("csum_tied_zero", {16'd0, csum}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
